// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the seq_det pattern detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_det_pkg;

    // Supported pattern lengths.
    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    // Ceiling log2, never below 1 so that a port width is always legal.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    // Longest proper prefix of the pattern (first-received bit at width-1)
    // that is also a suffix of it: the progress to resume from after an
    // overlapping match.
    function automatic int kmp_fallback(input logic [PAT_W_MAX-1:0] pat, input int width);
        int                   best;
        logic [PAT_W_MAX-1:0] mask;
        best = 0;
        for (int k = 1; k < width; k++) begin
            mask = {PAT_W_MAX{1'b1}} >> (PAT_W_MAX - k);
            if (((pat >> (width - k)) & mask) == (pat & mask)) begin
                best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_det_prefix_match.sv
// Longest pattern prefix matching a suffix of {history, din}, capped at PAT_W-1.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: hist (newest bit at [0]), hist_len (valid history bits), din, match_len.
module seq_det_prefix_match
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               PW      = clog2(PAT_W)
) (
    input  logic [PAT_W-2:0] hist,
    input  logic [PW-1:0]    hist_len,
    input  logic             din,
    output logic [PW-1:0]    match_len
);

    logic [PAT_W-1:0] seq;
    logic [PAT_W-1:0] pref;
    logic [PAT_W-1:0] mask;

    // A length-k prefix ends on din, so it lines up with the low k bits of
    // seq. Only the hist_len+1 genuinely received bits may take part, which
    // keeps stale zeros in an emptied history from faking a match.
    always_comb begin
        seq       = {hist, din};
        pref      = '0;
        mask      = '0;
        match_len = '0;
        for (int k = 1; k < PAT_W; k++) begin
            pref = PATTERN >> (PAT_W - k);
            mask = {PAT_W{1'b1}} >> (PAT_W - k);
            if ((((seq ^ pref) & mask) == '0) && (k <= int'(hist_len) + 1)) begin
                match_len = PW'(k);
            end
        end
    end

endmodule

// File: rtl/seq_det_fsm.sv
// Serial pattern detector with same-cycle Mealy hit, registered Moore hit and optional saturating hit counter.
// Latency: mealy_hit 0 cycles, moore_hit/progress/hit_cnt 1 cycle after the consuming edge.
// Backpressure: none; en gates consumption, clear discards state and wins over en.
// Ports: clk, reset (async high), en, din, clear -> mealy_hit, moore_hit, progress, hit_cnt, cnt_sat.
// Build option: define SEQDET_COUNT_EN to implement hit_cnt/cnt_sat; otherwise both are tied to 0.
module seq_det_fsm
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,        // 2..16
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,  // bit PAT_W-1 arrives first
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8         // 1..16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    din,
    input  logic                    clear,
    output logic                    mealy_hit,
    output logic                    moore_hit,
    output logic [clog2(PAT_W)-1:0] progress,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic                    cnt_sat
);

    localparam int            PW     = clog2(PAT_W);
    localparam logic [PW-1:0] LAST   = PW'(PAT_W - 1);
    localparam logic [PW-1:0] KMP_FB = PW'(kmp_fallback(16'(PATTERN), PAT_W));

    logic [PAT_W-2:0] hist_q, hist_d;
    logic [PW-1:0]    hist_len_q, hist_len_d;
    logic [PW-1:0]    progress_q, progress_d;
    logic             moore_hit_q, moore_hit_d;
    logic [PW-1:0]    match_len;

    seq_det_prefix_match #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .PW      (PW)
    ) u_prefix_match (
        .hist      (hist_q),
        .hist_len  (hist_len_q),
        .din       (din),
        .match_len (match_len)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q      <= '0;
            hist_len_q  <= '0;
            progress_q  <= '0;
            moore_hit_q <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            hist_len_q  <= hist_len_d;
            progress_q  <= progress_d;
            moore_hit_q <= moore_hit_d;
        end
    end

    // Next state.
    always_comb begin
        hist_d      = hist_q;
        hist_len_d  = hist_len_q;
        progress_d  = progress_q;
        moore_hit_d = mealy_hit;
        if (clear) begin
            hist_d     = '0;
            hist_len_d = '0;
            progress_d = '0;
        end else if (en) begin
            hist_d     = (hist_q << 1) | (PAT_W - 1)'(din);
            hist_len_d = (hist_len_q == LAST) ? LAST : hist_len_q + 1'b1;
            if (!mealy_hit) begin
                progress_d = match_len;
            end else if (OVERLAP) begin
                progress_d = KMP_FB;
            end else begin
                hist_d     = '0;
                hist_len_d = '0;
                progress_d = '0;
            end
        end
    end

    // Outputs. mealy_hit is a direct combinational path from en/din/clear.
    always_comb begin
        mealy_hit = en & ~clear & (progress_q == LAST) & (din == PATTERN[0]);
        moore_hit = moore_hit_q;
        progress  = progress_q;
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (mealy_hit && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt = cnt_q;
    assign cnt_sat = &cnt_q;
`else
    assign hit_cnt = '0;
    assign cnt_sat = 1'b0;
`endif

endmodule
